// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: control codes, MIPS opcode/funct constants and the
// issue-stage decode helper. Used by both the ALU and its issue stage.
package alu_defs;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_NOR  = 3'b110,
        ALU_OR   = 3'b111
    } alu_ctrl_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_NAND = 6'h2C;

    typedef struct packed {
        logic      legal;
        logic      use_imm;
        logic      sign_ext;
        alu_ctrl_e ctrl;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        dec_t d;
        d = '{legal: 1'b0, use_imm: 1'b0, sign_ext: 1'b0, ctrl: ALU_ADD};
        case (opcode)
            OP_RTYPE: begin
                d.legal = 1'b1;
                case (funct)
                    FN_ADD:  d.ctrl = ALU_ADD;
                    FN_SUB:  d.ctrl = ALU_SUB;
                    FN_XOR:  d.ctrl = ALU_XOR;
                    FN_SLT:  d.ctrl = ALU_SLT;
                    FN_AND:  d.ctrl = ALU_AND;
                    FN_NAND: d.ctrl = ALU_NAND;
                    FN_NOR:  d.ctrl = ALU_NOR;
                    FN_OR:   d.ctrl = ALU_OR;
                    default: d.legal = 1'b0;
                endcase
            end
            OP_ADDI: d = '{legal: 1'b1, use_imm: 1'b1, sign_ext: 1'b1, ctrl: ALU_ADD};
            OP_SLTI: d = '{legal: 1'b1, use_imm: 1'b1, sign_ext: 1'b1, ctrl: ALU_SLT};
            OP_ANDI: d = '{legal: 1'b1, use_imm: 1'b1, sign_ext: 1'b0, ctrl: ALU_AND};
            OP_ORI:  d = '{legal: 1'b1, use_imm: 1'b1, sign_ext: 1'b0, ctrl: ALU_OR};
            OP_XORI: d = '{legal: 1'b1, use_imm: 1'b1, sign_ext: 1'b0, ctrl: ALU_XOR};
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry pipeline buffer: a registered output stage plus one skid entry.
// in_ready is registered and simply reflects "skid entry free".
module alu_skid_buffer #(
    parameter int W = 67
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid holds its payload stable until that edge.
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_ready_q, in_ready_d;
    logic         fire;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        fire         = out_valid_q & out_ready;
        if (skid_valid_q) begin
            // in_ready is low here, so no push can arrive alongside the drain
            if (fire) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || fire) begin
            out_valid_d = push_valid;
            if (push_valid) out_data_d = push_data;
        end else if (push_valid) begin
            skid_valid_d = 1'b1;
            skid_data_d  = push_data;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the ALU: decodes opcode/funct, selects operand B
// and buffers {a,b,control}. Define ALU_ISSUE_STATS_EN for issue/illegal counters.
module alu_issue_stage
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm16,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [2:0]       control,
    output logic             illegal
`ifdef ALU_ISSUE_STATS_EN
   ,output logic [15:0]      issued_cnt,
    output logic [15:0]      illegal_cnt
`endif
);

    localparam int PW = 2 * WIDTH + 3;

    dec_t             dec;
    logic             accept;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] b_sel;
    logic [PW-1:0]    out_data;
    logic             illegal_q, illegal_d;

    always_comb begin
        dec       = decode(opcode, funct);
        accept    = in_valid & in_ready;
        imm_ext   = dec.sign_ext ? {{(WIDTH-16){imm16[15]}}, imm16}
                                 : {{(WIDTH-16){1'b0}}, imm16};
        b_sel     = dec.use_imm ? imm_ext : rt_val;
        // Illegal ops are consumed here and never reach the buffer
        illegal_d = accept & !dec.legal;
    end

    always_ff @(posedge clk) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end

    alu_skid_buffer #(.W(PW)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push_valid (accept & dec.legal),
        .push_data  ({rs_val, b_sel, dec.ctrl}),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    assign a       = out_data[PW-1 -: WIDTH];
    assign b       = out_data[WIDTH+2 -: WIDTH];
    assign control = out_data[2:0];
    assign illegal = illegal_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issued_cnt_q, issued_cnt_d;
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        issued_cnt_d  = issued_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (out_valid && out_ready && issued_cnt_q != 16'hFFFF)
            issued_cnt_d = issued_cnt_q + 16'd1;
        if (illegal_q && illegal_cnt_q != 16'hFFFF)
            illegal_cnt_d = illegal_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_cnt_q  <= '0;
            illegal_cnt_q <= '0;
        end else begin
            issued_cnt_q  <= issued_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign issued_cnt  = issued_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode table, backpressure/skid,
// illegal pulses, throughput and mid-operation reset.
module tb_alu_issue_stage;

    localparam int W  = 32;
    localparam int PW = 2 * W + 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  rt_val;
    logic [15:0]   imm16;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    control;
    logic          illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]   issued_cnt;
    logic [15:0]   illegal_cnt;
`endif

    alu_issue_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct     (funct),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .imm16     (imm16),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .control   (control),
        .illegal   (illegal)
`ifdef ALU_ISSUE_STATS_EN
       ,.issued_cnt  (issued_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [5:0]   opcode;
        logic [5:0]   funct;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [15:0]  imm;
        logic         legal;
        logic [W-1:0] eb;
        logic [2:0]   ec;
    } vec_t;

    logic [PW-1:0] exp_q[$];
    int  n_cmp   = 0;
    int  n_fail  = 0;
    int  fires   = 0;
    int  n_ill   = 0;
    logic exp_ill = 1'b0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            n_cmp++;
            if (illegal !== exp_ill) begin
                n_fail++;
                $display("FAIL illegal_pulse: got %b expected %b at cycle %0d", illegal, exp_ill, cyc);
            end
            exp_ill = 1'b0;
            if (out_valid && out_ready) begin
                fires++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_issue: got %h expected no output", {a, b, control});
                end else begin
                    logic [PW-1:0] e;
                    e = exp_q.pop_front();
                    if ({a, b, control} !== e) begin
                        n_fail++;
                        $display("FAIL issue_data: got %h expected %h", {a, b, control}, e);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input vec_t v);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        opcode   = v.opcode;
        funct    = v.funct;
        rs_val   = v.rs;
        rt_val   = v.rt;
        imm16    = v.imm;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
        end else if (v.legal) begin
            exp_q.push_back({v.rs, v.eb, v.ec});
        end else begin
            exp_ill = 1'b1;
            n_ill++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", PW'(exp_q.size()), '0);
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [W-1:0] rs,
                                input logic [W-1:0] rt, input logic [15:0] imm, input logic legal,
                                input logic [W-1:0] eb, input logic [2:0] ec);
        vec_t v;
        v = '{opcode: op, funct: fn, rs: rs, rt: rt, imm: imm, legal: legal, eb: eb, ec: ec};
        return v;
    endfunction

    vec_t vecs[17];
    vec_t v;
    int   start;
    int   f0;

    initial begin
        vecs[0]  = mk(6'h00, 6'h20, 32'd1,        32'hFFFF_FFFB, 16'hAAAA, 1, 32'hFFFF_FFFB, 3'b000);
        vecs[1]  = mk(6'h00, 6'h22, 32'd10,       32'd3,         16'h5555, 1, 32'd3,         3'b001);
        vecs[2]  = mk(6'h00, 6'h26, 32'h1234_5678,32'h0F0F_0F0F, 16'h0001, 1, 32'h0F0F_0F0F, 3'b010);
        vecs[3]  = mk(6'h00, 6'h2A, 32'h8000_0000,32'h0000_0001, 16'hFFFF, 1, 32'h0000_0001, 3'b011);
        vecs[4]  = mk(6'h00, 6'h24, 32'hDEAD_BEEF,32'hFFFF_0000, 16'h0000, 1, 32'hFFFF_0000, 3'b100);
        vecs[5]  = mk(6'h00, 6'h2C, 32'hCAFE_F00D,32'h0000_FFFF, 16'h1234, 1, 32'h0000_FFFF, 3'b101);
        vecs[6]  = mk(6'h00, 6'h27, 32'h0,        32'h0,         16'h8000, 1, 32'h0,         3'b110);
        vecs[7]  = mk(6'h00, 6'h25, 32'hFFFF_FFFF,32'hA5A5_A5A5, 16'h7FFF, 1, 32'hA5A5_A5A5, 3'b111);
        vecs[8]  = mk(6'h08, 6'h20, 32'd7,        32'h1111_1111, 16'hFFFF, 1, 32'hFFFF_FFFF, 3'b000);
        vecs[9]  = mk(6'h0D, 6'h22, 32'd9,        32'h2222_2222, 16'hFFFF, 1, 32'h0000_FFFF, 3'b111);
        vecs[10] = mk(6'h0A, 6'h00, 32'd5,        32'h3333_3333, 16'h8000, 1, 32'hFFFF_8000, 3'b011);
        vecs[11] = mk(6'h0C, 6'h3F, 32'd6,        32'h4444_4444, 16'h8001, 1, 32'h0000_8001, 3'b100);
        vecs[12] = mk(6'h0E, 6'h25, 32'd8,        32'h5555_5555, 16'h1234, 1, 32'h0000_1234, 3'b010);
        vecs[13] = mk(6'h08, 6'h00, 32'd2,        32'h6666_6666, 16'h7FFF, 1, 32'h0000_7FFF, 3'b000);
        vecs[14] = mk(6'h00, 6'h3F, 32'd3,        32'd4,         16'h0000, 0, 32'h0,         3'b000);
        vecs[15] = mk(6'h23, 6'h20, 32'd3,        32'd4,         16'h0010, 0, 32'h0,         3'b000);
        vecs[16] = mk(6'h00, 6'h20, 32'd100,      32'd23,        16'h0000, 1, 32'd23,        3'b000);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct = '0; rs_val = '0; rt_val = '0; imm16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", PW'(in_ready), '0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", PW'(out_valid), '0);
        chk("reset_abc", {a, b, control}, '0);
        chk("reset_illegal", PW'(illegal), '0);
`ifdef ALU_ISSUE_STATS_EN
        chk("reset_counters", PW'({issued_cnt, illegal_cnt}), '0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        chk("in_ready_after_reset", PW'(in_ready), PW'(1));
        @(posedge clk); #1;

        // First op: output one cycle after accept
        send(vecs[0]);
        @(negedge clk);
        chk("first_latency_valid", PW'(out_valid), PW'(1));
        chk("first_latency_abc", {a, b, control}, {32'd1, 32'hFFFF_FFFB, 3'b000});
        @(posedge clk); #1;

        // Decode table
        for (int i = 1; i < 17; i++) begin
            send(vecs[i]);
            if (!vecs[i].legal) begin
                @(negedge clk);
                chk("illegal_no_output", PW'(out_valid), '0);
                @(posedge clk); #1;
            end
        end
        drain();

        // Table again with random backpressure
        for (int i = 0; i < 17; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            send(vecs[i]);
        end
        drain();

        // Stall: two ops fill output and skid, then release in order
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(mk(6'h00, 6'h20, 32'h11, 32'h22, 16'h0, 1, 32'h22, 3'b000));
        send(mk(6'h00, 6'h22, 32'h33, 32'h44, 16'h0, 1, 32'h44, 3'b001));
        @(negedge clk);
        chk("skid_full_in_ready", PW'(in_ready), '0);
        chk("stall_head_a", PW'(a), PW'(32'h11));
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_hold_abc", {a, b, control}, {32'h11, 32'h22, 3'b000});
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("skid_drain_a", PW'(a), PW'(32'h33));
        chk("in_ready_reasserted", PW'(in_ready), PW'(1));
        drain();

        // Throughput: 8 back-to-back ops
        @(posedge clk); #1;
        start = cyc;
        f0    = fires;
        for (int i = 0; i < 8; i++) begin
            v = mk(6'h00, 6'h20, W'($urandom), W'($urandom), 16'h0, 1, 32'h0, 3'b000);
            v.eb = v.rt;
            send(v);
        end
        chk("throughput_accept_cycles", PW'(cyc - start), PW'(8));
        @(negedge clk); #1;
        chk("throughput_issues", PW'(fires - f0), PW'(8));
        drain();

        // Reset with skid full
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(mk(6'h0D, 6'h00, 32'h77, 32'h0, 16'h00F0, 1, 32'h0000_00F0, 3'b111));
        send(mk(6'h00, 6'h25, 32'h88, 32'h99, 16'h0, 1, 32'h99, 3'b111));
        @(negedge clk);
        chk("pre_reset_skid_full", PW'(in_ready), '0);
`ifdef ALU_ISSUE_STATS_EN
        chk("issued_cnt", PW'(issued_cnt), PW'(fires));
        chk("illegal_cnt", PW'(illegal_cnt), PW'(n_ill));
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_reset_out_valid", PW'(out_valid), '0);
        chk("mid_reset_in_ready", PW'(in_ready), '0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ill = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_abc", {a, b, control}, '0);
`ifdef ALU_ISSUE_STATS_EN
        chk("post_reset_counters", PW'({issued_cnt, illegal_cnt}), '0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_reset_in_ready", PW'(in_ready), PW'(1));
        chk("post_reset_out_valid", PW'(out_valid), '0);
        @(posedge clk); #1;

        send(vecs[9]);
        @(negedge clk);
        chk("post_reset_op", {a, b, control}, {32'd9, 32'h0000_FFFF, 3'b111});
        @(posedge clk); #1;
        drain();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
